// File: rtl/iter_div_pkg.sv
// Shared definitions for the iterative divider: operand-size codes, FSM state
// encodings and the size-to-width helper.
package iter_div_pkg;

    localparam logic [1:0] SZ_8  = 2'd0;
    localparam logic [1:0] SZ_16 = 2'd1;
    localparam logic [1:0] SZ_32 = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_ITER  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Operand width N for a size code; the unused code 2'b11 behaves as 32-bit.
    function automatic logic [6:0] size_to_n(input logic [1:0] sz);
        logic [6:0] n;
        case (sz)
            SZ_8:    n = 7'd8;
            SZ_16:   n = 7'd16;
            default: n = 7'd32;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/iter_div_step.sv
// Combinational restoring-division slice: BITS_PER_CYCLE chained
// compare/subtract/shift stages, most significant quotient bit first.
module iter_div_step
    import iter_div_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [XLEN-1:0]           rem_in,
    input  logic [BITS_PER_CYCLE-1:0] bits_in,
    input  logic [XLEN-1:0]           divisor,
    output logic [XLEN-1:0]           rem_out,
    output logic [BITS_PER_CYCLE-1:0] q_out
);

    logic [XLEN-1:0] part_s [0:BITS_PER_CYCLE];

    assign part_s[0] = rem_in;

    // The partial remainder stays below the divisor, so the true difference
    // always fits in XLEN bits; the extra trial bit only feeds the compare.
    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_stage
        logic [XLEN:0]   trial_s;
        logic [XLEN-1:0] diff_s;
        logic            ge_s;

        assign trial_s   = {part_s[g], bits_in[BITS_PER_CYCLE-1-g]};
        assign ge_s      = (trial_s >= {1'b0, divisor});
        assign diff_s    = trial_s[XLEN-1:0] - divisor;
        assign q_out[BITS_PER_CYCLE-1-g] = ge_s;
        assign part_s[g+1] = ge_s ? diff_s : trial_s[XLEN-1:0];
    end

    assign rem_out = part_s[BITS_PER_CYCLE];

endmodule

// File: rtl/iter_div.sv
// Multi-cycle DIV/IDIV unit for 8/16/32-bit operands with valid/ready handshake.
// Optional macro DIV_FASTPATH_EN: skip iteration when |dividend| < |divisor|.
module iter_div
    import iter_div_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op_signed,
    input  logic [1:0]      op_size,
    input  logic [XLEN-1:0] dividend_hi,
    input  logic [XLEN-1:0] dividend_lo,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            fault_de
);

    localparam logic [XLEN-1:0] ZERO_C = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONE_C  = {{(XLEN-1){1'b0}}, 1'b1};

    state_t state_r, state_nx_s;

    logic            in_ready_r, out_valid_r, fault_de_r;
    logic [XLEN-1:0] quotient_r, remainder_r;

    logic            signed_r, pfault_r;
    logic [1:0]      size_r;
    logic [XLEN-1:0] hi_r, lo_r, dvs_r;
    logic [XLEN-1:0] rem_r, shift_r, dvs_mag_r, q_r;
    logic [6:0]      cnt_r;

    logic            accept_s;
    logic [6:0]      n_s;
    logic [XLEN-1:0] mask_s, top_s, hi_m_s, lo_m_s, dvs_m_s;
    logic [XLEN-1:0] hi_mag_s, lo_mag_s, dvs_mag_s;
    logic            dvd_neg_s, dvs_neg_s, prep_fault_s, fast_s;
    logic [XLEN-1:0] step_rem_s;
    logic [BITS_PER_CYCLE-1:0] step_q_s;
    logic [XLEN-1:0] q_mag_s, r_mag_s, q_fin_s, r_fin_s;
    logic            neg_q_s, range_fault_s, fix_fault_s;

    assign accept_s  = in_valid & in_ready_r & ~flush;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign fault_de  = fault_de_r;

    iter_div_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .rem_in  (rem_r),
        .bits_in (shift_r[XLEN-1 -: BITS_PER_CYCLE]),
        .divisor (dvs_mag_r),
        .rem_out (step_rem_s),
        .q_out   (step_q_s)
    );

    // Size masks and operand magnitudes derived from the latched request.
    always_comb begin
        n_s       = size_to_n(size_r);
        mask_s    = ~({XLEN{1'b1}} << n_s);
        top_s     = mask_s ^ (mask_s >> 1);
        hi_m_s    = hi_r & mask_s;
        lo_m_s    = lo_r & mask_s;
        dvs_m_s   = dvs_r & mask_s;
        dvd_neg_s = signed_r & (|(hi_m_s & top_s));
        dvs_neg_s = signed_r & (|(dvs_m_s & top_s));
        if (dvd_neg_s) begin
            // 2N-bit negate: the low half's carry-out only occurs when it is zero.
            lo_mag_s = (~lo_m_s + ONE_C) & mask_s;
            hi_mag_s = (~hi_m_s + {{(XLEN-1){1'b0}}, (lo_m_s == ZERO_C)}) & mask_s;
        end else begin
            lo_mag_s = lo_m_s;
            hi_mag_s = hi_m_s;
        end
        if (dvs_neg_s) begin
            dvs_mag_s = (~dvs_m_s + ONE_C) & mask_s;
        end else begin
            dvs_mag_s = dvs_m_s;
        end
        prep_fault_s = (dvs_mag_s == ZERO_C) | (hi_mag_s >= dvs_mag_s);
`ifdef DIV_FASTPATH_EN
        fast_s = (hi_mag_s == ZERO_C) & (lo_mag_s < dvs_mag_s);
`else
        fast_s = 1'b0;
`endif
    end

    // Sign restoration and signed range check applied in FIXUP.
    always_comb begin
        q_mag_s = q_r & mask_s;
        r_mag_s = rem_r & mask_s;
        neg_q_s = dvd_neg_s ^ dvs_neg_s;
        if (neg_q_s) begin
            q_fin_s       = (~q_mag_s + ONE_C) & mask_s;
            range_fault_s = (q_mag_s > top_s);
        end else begin
            q_fin_s       = q_mag_s;
            range_fault_s = signed_r & (q_mag_s >= top_s);
        end
        if (dvd_neg_s) begin
            r_fin_s = (~r_mag_s + ONE_C) & mask_s;
        end else begin
            r_fin_s = r_mag_s;
        end
        fix_fault_s = pfault_r | range_fault_s;
    end

    // Next-state logic; PREP-resolved outcomes still pass through FIXUP so
    // results are committed from a single place.
    always_comb begin
        state_nx_s = state_r;
        if (flush) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_nx_s = in_valid ? ST_PREP : ST_IDLE;
                ST_PREP:  state_nx_s = (prep_fault_s | fast_s) ? ST_FIXUP : ST_ITER;
                ST_ITER:  state_nx_s = (cnt_r == 7'd1) ? ST_FIXUP : ST_ITER;
                ST_FIXUP: state_nx_s = ST_DONE;
                ST_DONE:  state_nx_s = out_ready ? ST_IDLE : ST_DONE;
                default:  state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State register with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_DONE);
        end
    end

    // Request capture and iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signed_r  <= 1'b0;
            size_r    <= SZ_8;
            hi_r      <= ZERO_C;
            lo_r      <= ZERO_C;
            dvs_r     <= ZERO_C;
            pfault_r  <= 1'b0;
            rem_r     <= ZERO_C;
            shift_r   <= ZERO_C;
            dvs_mag_r <= ZERO_C;
            q_r       <= ZERO_C;
            cnt_r     <= 7'd0;
        end else begin
            if (accept_s) begin
                signed_r <= op_signed;
                size_r   <= op_size;
                hi_r     <= dividend_hi;
                lo_r     <= dividend_lo;
                dvs_r    <= divisor;
                pfault_r <= 1'b0;
            end
            case (state_r)
                ST_PREP: begin
                    dvs_mag_r <= dvs_mag_s;
                    rem_r     <= fast_s ? lo_mag_s : hi_mag_s;
                    shift_r   <= lo_mag_s << (7'(XLEN) - n_s);
                    q_r       <= ZERO_C;
                    cnt_r     <= n_s / 7'(BITS_PER_CYCLE);
                    pfault_r  <= prep_fault_s;
                end
                ST_ITER: begin
                    rem_r   <= step_rem_s;
                    shift_r <= shift_r << BITS_PER_CYCLE;
                    q_r     <= {q_r[XLEN-BITS_PER_CYCLE-1:0], step_q_s};
                    cnt_r   <= cnt_r - 7'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: loaded in FIXUP, held through DONE, cleared on handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient_r  <= ZERO_C;
            remainder_r <= ZERO_C;
            fault_de_r  <= 1'b0;
        end else if (flush || (state_r == ST_DONE && out_ready)) begin
            quotient_r  <= ZERO_C;
            remainder_r <= ZERO_C;
            fault_de_r  <= 1'b0;
        end else if (state_r == ST_FIXUP) begin
            quotient_r  <= fix_fault_s ? ZERO_C : q_fin_s;
            remainder_r <= fix_fault_s ? ZERO_C : r_fin_s;
            fault_de_r  <= fix_fault_s;
        end
    end

endmodule

// File: tb/tb_iter_div.sv
// Directed self-checking bench for iter_div (XLEN=32, one quotient bit per cycle).
// Latency expectations follow DIV_FASTPATH_EN when the bench is built with it.
module tb_iter_div;
    import iter_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op_signed = 1'b0;
    logic [1:0]  op_size = 2'd0;
    logic [31:0] dividend_hi = 32'd0;
    logic [31:0] dividend_lo = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        fault_de;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    iter_div #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_signed   (op_signed),
        .op_size     (op_size),
        .dividend_hi (dividend_hi),
        .dividend_lo (dividend_lo),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .fault_de    (fault_de)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present one request, then scramble the inputs to prove they were latched.
    task automatic start_op(input logic sgn, input logic [1:0] sz,
                            input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] d);
        @(negedge clk);
        op_signed = sgn; op_size = sz;
        dividend_hi = hi; dividend_lo = lo; divisor = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_signed = ~sgn; op_size = 2'($urandom);
        dividend_hi = $urandom; dividend_lo = $urandom; divisor = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [1:0] sz,
                          input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] d,
                          input logic [31:0] eq, input logic [31:0] er, input logic ef,
                          input int lat_exp, input logic fast_ok, input int hold);
        int lat;
        int lat_want;
        check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
        start_op(sgn, sz, hi, lo, d);
        wait_valid(lat);
        lat_want = lat_exp;
`ifdef DIV_FASTPATH_EN
        if (fast_ok) lat_want = 2;
`else
        if (fast_ok) lat_want = lat_exp;
`endif
        check_eq({tag, " latency"}, 32'(lat), 32'(lat_want));
        check_eq({tag, " q"}, quotient, eq);
        check_eq({tag, " r"}, remainder, er);
        check_eq({tag, " de"}, 32'(fault_de), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, " hold"}, {out_valid, quotient[30:0]}, {1'b1, eq[30:0]});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, " drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        int lat;
        #2 rst_n = 1'b0;
        #1;
        check_eq("reset in_ready", 32'(in_ready), 32'd1);
        check_eq("reset out_valid", 32'(out_valid), 32'd0);
        check_eq("reset q", quotient, 32'd0);
        check_eq("reset r", remainder, 32'd0);
        check_eq("reset de", 32'(fault_de), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //      tag          sgn   size   hi            lo            divisor       q             r             de    lat fast hold
        run_op("u32",        1'b0, SZ_32, 32'h0,        32'h64,       32'd7,        32'hE,        32'd2,        1'b0, 34, 1'b0, 5);
        run_op("div0",       1'b0, SZ_16, 32'h0,        32'h1234,     32'd0,        32'd0,        32'd0,        1'b1, 2,  1'b0, 0);
        run_op("u8 ovf",     1'b0, SZ_8,  32'h02,       32'h00,       32'h02,       32'd0,        32'd0,        1'b1, 2,  1'b0, 0);
        run_op("s16",        1'b1, SZ_16, 32'hABCDFFFF, 32'h1234FFF9, 32'h55550002, 32'hFFFD,     32'hFFFF,     1'b0, 18, 1'b0, 0);
        run_op("s32 ovf",    1'b1, SZ_32, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'd0,        1'b1, 34, 1'b0, 0);
        run_op("u8",         1'b0, SZ_8,  32'h01,       32'h2C,       32'h07,       32'h2A,       32'h06,       1'b0, 10, 1'b0, 0);
        run_op("s8",         1'b1, SZ_8,  32'h00,       32'h64,       32'hF9,       32'hF2,       32'h02,       1'b0, 10, 1'b0, 0);
        run_op("s8 -128/-1", 1'b1, SZ_8,  32'hFF,       32'h80,       32'hFF,       32'd0,        32'd0,        1'b1, 10, 1'b0, 0);
        run_op("s8 -128/1",  1'b1, SZ_8,  32'hFF,       32'h80,       32'h01,       32'h80,       32'h00,       1'b0, 10, 1'b0, 0);
        run_op("u16 small",  1'b0, SZ_16, 32'h0,        32'h5,        32'h9,        32'h0,        32'h5,        1'b0, 18, 1'b1, 0);
        run_op("s16 small",  1'b1, SZ_16, 32'hFFFF,     32'hFFFB,     32'h9,        32'h0,        32'hFFFB,     1'b0, 18, 1'b1, 0);
        run_op("u32 2^32",   1'b0, SZ_32, 32'h1,        32'h0,        32'h10,       32'h10000000, 32'h0,        1'b0, 34, 1'b0, 0);
        run_op("u32 max",    1'b0, SZ_32, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34, 1'b0, 0);
        run_op("s32",        1'b1, SZ_32, 32'h0,        32'h64,       32'hFFFFFFF9, 32'hFFFFFFF2, 32'h2,        1'b0, 34, 1'b0, 0);
        run_op("s16 ovf",    1'b1, SZ_16, 32'h1,        32'h0,        32'h1,        32'd0,        32'd0,        1'b1, 2,  1'b0, 0);
        run_op("size 11",    1'b0, 2'b11, 32'h0,        32'h3E8,      32'd3,        32'h14D,      32'd1,        1'b0, 34, 1'b0, 0);

        // Flush while iterating: result must never appear.
        start_op(1'b0, SZ_32, 32'h0, 32'h64, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush in_ready", 32'(in_ready), 32'd1);
        check_eq("flush out_valid", 32'(out_valid), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check_eq("flush no result", 32'(seen), 32'd0);

        // Flush with in_valid in IDLE must not accept.
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1;
        op_size = SZ_8; dividend_hi = 32'h0; dividend_lo = 32'h10; divisor = 32'h0;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush idle in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check_eq("flush idle no result", 32'(seen), 32'd0);

        // Reset mid-iteration.
        start_op(1'b0, SZ_32, 32'h0, 32'h64, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst iter in_ready", 32'(in_ready), 32'd1);
        check_eq("rst iter out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while a result is pending: it is dropped at once.
        start_op(1'b0, SZ_8, 32'h01, 32'h2C, 32'h07);
        wait_valid(lat);
        check_eq("pend q", quotient, 32'h2A);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst done out_valid", 32'(out_valid), 32'd0);
        check_eq("rst done q", quotient, 32'd0);
        check_eq("rst done r", remainder, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("after rst",  1'b1, SZ_16, 32'hFFFF,     32'hFFF9,     32'h0002,     32'hFFFD,     32'hFFFF,     1'b0, 18, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
